// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: memory FSM encoding
// and EX operand forward-select codes.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // The younger producer (MEM) wins over WB when both write the same register.
  function automatic logic [1:0] fwd_select(input logic [3:0] src,
                                            input logic [3:0] mem_dest,
                                            input logic       mem_wb_en,
                                            input logic [3:0] wb_dest,
                                            input logic       wb_wb_en);
    if (mem_wb_en && (src == mem_dest)) return FWD_MEM;
    else if (wb_wb_en && (src == wb_dest)) return FWD_WB;
    else return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_forwarding.sv
// forwarding_unit: per-operand EX source selects. Only compiled when
// PIPELINE_CTRL_FORWARDING_EN is defined.
`ifdef PIPELINE_CTRL_FORWARDING_EN
module forwarding_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [3:0] ex_src1_i,
  input  logic [3:0] ex_src2_i,
  input  logic [3:0] mem_dest_i,
  input  logic       mem_wb_en_i,
  input  logic [3:0] wb_dest_i,
  input  logic       wb_wb_en_i,
  output logic [1:0] sel_src1_o,
  output logic [1:0] sel_src2_o
);

  assign sel_src1_o = fwd_select(ex_src1_i, mem_dest_i, mem_wb_en_i, wb_dest_i, wb_wb_en_i);
  assign sel_src2_o = fwd_select(ex_src2_i, mem_dest_i, mem_wb_en_i, wb_dest_i, wb_wb_en_i);

endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: RAW-hazard, branch-flush and data-memory stall control for the
// five-stage pipeline. Define PIPELINE_CTRL_FORWARDING_EN to add EX forwarding.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] ID_src1,
  input  logic [3:0] ID_src2,
  input  logic       ID_two_src,
  input  logic [3:0] EX_src1,
  input  logic [3:0] EX_src2,
  input  logic       EXE_WB_EN,
  input  logic       EXE_MEM_R_EN,
  input  logic [3:0] EXE_Dest,
  input  logic       MEM_WB_EN,
  input  logic [3:0] MEM_Dest,
  input  logic       WB_WB_EN,
  input  logic [3:0] WB_Dest,
  input  logic       MEM_req,
  input  logic       SRAM_ready,
  input  logic       Branch_Taken,
  output logic       freeze_IF,
  output logic       freeze_ID,
  output logic       freeze_EX,
  output logic       freeze_MEM,
  output logic       flush_IF,
  output logic       bubble_ID,
  output logic [1:0] sel_src1,
  output logic [1:0] sel_src2,
  output logic       mem_timeout
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  mem_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  logic       memStall;
  logic       rawHazard;
  logic       unusedInputs;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // The counter includes the IDLE->WAIT request cycle, so it tracks stalled cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (MEM_req) begin
          state_d = WAIT;
          cnt_d   = 8'd1;
        end
      end
      WAIT: begin
        if (SRAM_ready) begin
          state_d = DONE;
          cnt_d   = '0;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    timeout_d = timeout_q | (cnt_d >= MaxWait);
  end

  assign memStall = MEM_req && (state_q != DONE);

`ifdef PIPELINE_CTRL_FORWARDING_EN
  logic [1:0] fwdSel1, fwdSel2;

  forwarding_unit u_fwd (
    .ex_src1_i   (EX_src1),
    .ex_src2_i   (EX_src2),
    .mem_dest_i  (MEM_Dest),
    .mem_wb_en_i (MEM_WB_EN),
    .wb_dest_i   (WB_Dest),
    .wb_wb_en_i  (WB_WB_EN),
    .sel_src1_o  (fwdSel1),
    .sel_src2_o  (fwdSel2)
  );

  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign rawHazard = EXE_MEM_R_EN &&
                     ((ID_src1 == EXE_Dest) || (ID_two_src && (ID_src2 == EXE_Dest)));
  assign sel_src1     = RST ? fwdSel1 : FWD_RF;
  assign sel_src2     = RST ? fwdSel2 : FWD_RF;
  assign unusedInputs = EXE_WB_EN;
`else
  assign rawHazard = (EXE_WB_EN && (ID_src1 == EXE_Dest)) ||
                     (MEM_WB_EN && (ID_src1 == MEM_Dest)) ||
                     (ID_two_src && ((EXE_WB_EN && (ID_src2 == EXE_Dest)) ||
                                     (MEM_WB_EN && (ID_src2 == MEM_Dest))));
  assign sel_src1     = FWD_RF;
  assign sel_src2     = FWD_RF;
  assign unusedInputs = ^{EX_src1, EX_src2, WB_WB_EN, WB_Dest, EXE_MEM_R_EN};
`endif

  // Memory stall freezes everything and defers branch/hazard actions; a taken
  // branch squashes ID, which makes any hazard on it irrelevant.
  always_comb begin
    freeze_IF  = 1'b0;
    freeze_ID  = 1'b0;
    freeze_EX  = 1'b0;
    freeze_MEM = 1'b0;
    flush_IF   = 1'b0;
    bubble_ID  = 1'b0;
    if (RST) begin
      if (memStall) begin
        freeze_IF  = 1'b1;
        freeze_ID  = 1'b1;
        freeze_EX  = 1'b1;
        freeze_MEM = 1'b1;
      end else if (Branch_Taken) begin
        flush_IF  = 1'b1;
        bubble_ID = 1'b1;
      end else if (rawHazard) begin
        freeze_IF = 1'b1;
        freeze_ID = 1'b1;
        bubble_ID = 1'b1;
      end
    end
  end

  assign mem_timeout = RST & timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl: table-driven hazard/branch vectors plus
// hand-written memory handshake, timeout and reset sequences.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int unsigned MAX_WAIT = 4;
  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] HAZ   = 6'b110001;
  localparam logic [5:0] BR    = 6'b000011;
  localparam logic [5:0] STALL = 6'b111100;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] ID_src1, ID_src2, EX_src1, EX_src2, EXE_Dest, MEM_Dest, WB_Dest;
  logic       ID_two_src, EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN, WB_WB_EN;
  logic       MEM_req, SRAM_ready, Branch_Taken;
  logic       freeze_IF, freeze_ID, freeze_EX, freeze_MEM, flush_IF, bubble_ID;
  logic [1:0] sel_src1, sel_src2;
  logic       mem_timeout;
  logic [5:0] ctrl;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       two;
    logic       exWb;
    logic       exLd;
    logic [3:0] exDest;
    logic       memWb;
    logic [3:0] memDest;
    logic       br;
    logic [5:0] expNf;
    logic [5:0] expF;
  } vec_t;

  vec_t vecs[11];

  pipeline_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_two_src(ID_two_src),
    .EX_src1(EX_src1), .EX_src2(EX_src2),
    .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN), .EXE_Dest(EXE_Dest),
    .MEM_WB_EN(MEM_WB_EN), .MEM_Dest(MEM_Dest),
    .WB_WB_EN(WB_WB_EN), .WB_Dest(WB_Dest),
    .MEM_req(MEM_req), .SRAM_ready(SRAM_ready), .Branch_Taken(Branch_Taken),
    .freeze_IF(freeze_IF), .freeze_ID(freeze_ID), .freeze_EX(freeze_EX),
    .freeze_MEM(freeze_MEM), .flush_IF(flush_IF), .bubble_ID(bubble_ID),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .mem_timeout(mem_timeout)
  );

  always #5 CLK = ~CLK;

  assign ctrl = {freeze_IF, freeze_ID, freeze_EX, freeze_MEM, flush_IF, bubble_ID};

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic clearHazard();
    ID_src1 = 4'd0; ID_src2 = 4'd0; ID_two_src = 1'b0;
    EX_src1 = 4'd0; EX_src2 = 4'd0;
    EXE_WB_EN = 1'b0; EXE_MEM_R_EN = 1'b0; EXE_Dest = 4'd0;
    MEM_WB_EN = 1'b0; MEM_Dest = 4'd0;
    WB_WB_EN = 1'b0; WB_Dest = 4'd0;
    Branch_Taken = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    ID_src1 = v.s1; ID_src2 = v.s2; ID_two_src = v.two;
    EXE_WB_EN = v.exWb; EXE_MEM_R_EN = v.exLd; EXE_Dest = v.exDest;
    MEM_WB_EN = v.memWb; MEM_Dest = v.memDest;
    Branch_Taken = v.br;
  endtask

  task automatic memStep(input logic req, input logic rdy, input logic [5:0] expCtrl,
                         input logic expTo, input string name);
    @(posedge CLK); #1;
    MEM_req = req;
    SRAM_ready = rdy;
    @(negedge CLK);
    checkOutput({name, " ctrl"}, {2'b00, ctrl}, {2'b00, expCtrl});
    checkOutput({name, " timeout"}, {7'd0, mem_timeout}, {7'd0, expTo});
  endtask

  initial begin
    //             s1    s2    two   exWb  exLd  exDest memWb memDest br    noFwd fwd
    vecs[0]  = '{4'd3, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0,  1'b0, HAZ,  NONE};
    vecs[1]  = '{4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 4'd0,  1'b0, NONE, NONE};
    vecs[2]  = '{4'd1, 4'd7, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7,  1'b0, HAZ,  NONE};
    vecs[3]  = '{4'd1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7,  1'b0, NONE, NONE};
    vecs[4]  = '{4'd3, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0,  1'b1, BR,   BR};
    vecs[5]  = '{4'd15,4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd15, 1'b0, HAZ,  NONE};
    vecs[6]  = '{4'd4, 4'd9, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0, 4'd0,  1'b0, HAZ,  HAZ};
    vecs[7]  = '{4'd4, 4'd9, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 4'd0,  1'b0, NONE, HAZ};
    vecs[8]  = '{4'd2, 4'd2, 1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 4'd6,  1'b0, NONE, NONE};
    vecs[9]  = '{4'd6, 4'd0, 1'b0, 1'b1, 1'b1, 4'd6, 1'b0, 4'd0,  1'b1, BR,   BR};
    vecs[10] = '{4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0,  1'b0, HAZ,  NONE};

    RST = 1'b0;
    clearHazard();
    MEM_req = 1'b0;
    SRAM_ready = 1'b0;
    applyStimulus(vecs[0]);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("in reset ctrl", {2'b00, ctrl}, 8'd0);
    checkOutput("in reset timeout", {7'd0, mem_timeout}, 8'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    clearHazard();
    @(negedge CLK);
    checkOutput("after reset ctrl", {2'b00, ctrl}, 8'd0);
    checkOutput("after reset sel", {4'd0, sel_src1, sel_src2}, 8'd0);

    $display("[TB] hazard/branch table");
    for (int i = 0; i < 11; i++) begin
      @(posedge CLK); #1;
      applyStimulus(vecs[i]);
      @(negedge CLK);
`ifdef PIPELINE_CTRL_FORWARDING_EN
      checkOutput($sformatf("vec%0d ctrl", i), {2'b00, ctrl}, {2'b00, vecs[i].expF});
`else
      checkOutput($sformatf("vec%0d ctrl", i), {2'b00, ctrl}, {2'b00, vecs[i].expNf});
      checkOutput($sformatf("vec%0d sel", i), {4'd0, sel_src1, sel_src2}, 8'd0);
`endif
    end
    clearHazard();

    $display("[TB] memory handshake");
    memStep(1'b1, 1'b0, STALL, 1'b0, "hs idle req");
    @(posedge CLK); #1;
    applyStimulus(vecs[4]);
    @(negedge CLK);
    checkOutput("hs branch deferred", {2'b00, ctrl}, {2'b00, STALL});
    clearHazard();
    memStep(1'b1, 1'b0, STALL, 1'b0, "hs wait2");
    memStep(1'b1, 1'b1, STALL, 1'b0, "hs wait3 ready");
    memStep(1'b1, 1'b0, NONE,  1'b0, "hs done");
    memStep(1'b0, 1'b0, NONE,  1'b0, "hs back idle");

    $display("[TB] stray ready and back-to-back");
    memStep(1'b0, 1'b1, NONE,  1'b0, "stray ready");
    memStep(1'b1, 1'b1, STALL, 1'b0, "b2b a idle");
    memStep(1'b1, 1'b1, STALL, 1'b0, "b2b a wait");
    memStep(1'b1, 1'b0, NONE,  1'b0, "b2b a done");
    memStep(1'b1, 1'b0, STALL, 1'b0, "b2b b idle");
    memStep(1'b1, 1'b1, STALL, 1'b0, "b2b b wait");
    memStep(1'b0, 1'b0, NONE,  1'b0, "b2b b done");

    $display("[TB] timeout");
    for (int k = 1; k <= 6; k++)
      memStep(1'b1, 1'b0, STALL, (k >= 5), $sformatf("to stall%0d", k));
    memStep(1'b1, 1'b1, STALL, 1'b1, "to ready");
    memStep(1'b0, 1'b0, NONE,  1'b1, "to done");
    memStep(1'b0, 1'b0, NONE,  1'b1, "to sticky");
    @(posedge CLK); #1;
    RST = 1'b0;
    applyStimulus(vecs[0]);
    @(negedge CLK);
    checkOutput("to reset ctrl", {2'b00, ctrl}, 8'd0);
    checkOutput("to reset timeout", {7'd0, mem_timeout}, 8'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    clearHazard();
    @(negedge CLK);
    checkOutput("to cleared", {7'd0, mem_timeout}, 8'd0);

    $display("[TB] reset mid-access");
    memStep(1'b1, 1'b0, STALL, 1'b0, "rst idle");
    memStep(1'b1, 1'b0, STALL, 1'b0, "rst wait");
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("rst low ctrl", {2'b00, ctrl}, 8'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    MEM_req = 1'b0;
    @(negedge CLK);
    checkOutput("rst release ctrl", {2'b00, ctrl}, 8'd0);
    memStep(1'b1, 1'b1, STALL, 1'b0, "rst new req");
    memStep(1'b1, 1'b1, STALL, 1'b0, "rst fsm was idle");
    memStep(1'b0, 1'b0, NONE,  1'b0, "rst done");

`ifdef PIPELINE_CTRL_FORWARDING_EN
    $display("[TB] forwarding selects");
    @(posedge CLK); #1;
    EX_src1 = 4'd5; EX_src2 = 4'd5; MEM_Dest = 4'd5; WB_Dest = 4'd5;
    MEM_WB_EN = 1'b1; WB_WB_EN = 1'b1;
    @(negedge CLK);
    checkOutput("fwd mem prio", {4'd0, sel_src1, sel_src2}, {4'd0, FWD_MEM, FWD_MEM});
    MEM_WB_EN = 1'b0;
    #1;
    checkOutput("fwd wb", {4'd0, sel_src1, sel_src2}, {4'd0, FWD_WB, FWD_WB});
    WB_WB_EN = 1'b0;
    #1;
    checkOutput("fwd none", {4'd0, sel_src1, sel_src2}, {4'd0, FWD_RF, FWD_RF});
    EX_src2 = 4'd6; WB_Dest = 4'd6; WB_WB_EN = 1'b1; MEM_WB_EN = 1'b1;
    #1;
    checkOutput("fwd mixed", {4'd0, sel_src1, sel_src2}, {4'd0, FWD_MEM, FWD_WB});
    clearHazard();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
